// File: rtl/fm_demod_decimator_if.sv
// Sample-stream bundle between the demodulator controller and the decimator:
// input strobe/config and the FIFO drain handshake toward the sample sink.
interface fm_demod_decimator_if #(parameter int FIFO_DEPTH = 4);
   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   logic                     enable;
   logic [2:0]               decim;
   logic                     dc_block;
   logic signed [15:0]       signal_in;
   logic signed [15:0]       out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [LEVEL_W-1:0]       level;
   logic                     overflow;

   modport master (
      output enable, decim, dc_block, signal_in, out_ready,
      input  out_data, out_valid, level, overflow
   );

   modport slave (
      input  enable, decim, dc_block, signal_in, out_ready,
      output out_data, out_valid, level, overflow
   );
endinterface

// File: rtl/fm_demod_decimator.sv
// Block-average decimator with optional leaky DC removal and a small FWFT
// output FIFO drained over valid/ready.
module fm_demod_decimator #(
   parameter int FIFO_DEPTH = 4,
   parameter int DC_SHIFT   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   fm_demod_decimator_if.slave  bus
);
   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int EW      = 16 + DC_SHIFT;

   logic signed [22:0]  acc;
   logic [6:0]          count;
   logic [2:0]          decim_r;
   logic [2:0]          decim_eff;
   logic [6:0]          last_idx;
   logic signed [22:0]  sum;
   logic signed [22:0]  mean_full;

   logic                s1_valid;
   logic signed [15:0]  s1_mean;

   logic signed [EW-1:0] dc_est;
   logic signed [EW-1:0] est_full;
   logic signed [16:0]   y17;
   logic signed [15:0]   y_sat;
   logic                 s2_valid;
   logic signed [15:0]   s2_y;

   logic [15:0]          mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [LEVEL_W-1:0]   level_r;
   logic                 ovf_r;
   logic                 full;
   logic                 pop;
   logic                 push_ok;

   // The block length is taken from the live decim input only at block start.
   assign decim_eff = (count == 7'd0) ? bus.decim : decim_r;
   assign last_idx  = 7'((8'd1 << decim_eff) - 8'd1);
   assign sum       = acc + {{7{bus.signal_in[15]}}, bus.signal_in};
   assign mean_full = sum >>> decim_eff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         count    <= '0;
         decim_r  <= '0;
         s1_valid <= 1'b0;
         s1_mean  <= '0;
      end else begin
         s1_valid <= 1'b0;
         if (bus.enable) begin
            if (count == 7'd0)
               decim_r <= bus.decim;
            if (count == last_idx) begin
               s1_mean  <= mean_full[15:0];
               s1_valid <= 1'b1;
               acc      <= '0;
               count    <= '0;
            end else begin
               acc   <= sum;
               count <= count + 7'd1;
            end
         end
      end
   end

   assign est_full = dc_est >>> DC_SHIFT;
   assign y17      = {s1_mean[15], s1_mean} - est_full[16:0];

   always_comb begin
      y_sat = y17[15:0];
      if (!y17[16] && y17[15])
         y_sat = 16'sh7fff;
      else if (y17[16] && !y17[15])
         y_sat = 16'sh8000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         dc_est   <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (!bus.dc_block)
            dc_est <= '0;
         if (s1_valid) begin
            if (bus.dc_block) begin
               s2_y   <= y_sat;
               dc_est <= dc_est + {{(EW-17){y17[16]}}, y17};
            end else begin
               s2_y <= s1_mean;
            end
         end
      end
   end

   // A pop frees the head slot, so a push into a full FIFO succeeds alongside it.
   assign full    = (level_r == LEVEL_W'(FIFO_DEPTH));
   assign pop     = (level_r != '0) && bus.out_ready;
   assign push_ok = s2_valid && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= s2_y;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_r <= '0;
         ovf_r   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push_ok && !pop)
            level_r <= level_r + LEVEL_W'(1);
         else if (!push_ok && pop)
            level_r <= level_r - LEVEL_W'(1);
         if (s2_valid && !push_ok)
            ovf_r <= 1'b1;
      end
   end

   assign bus.out_valid = (level_r != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
   assign bus.level     = level_r;
   assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_fm_demod_decimator.sv
// Directed bench for fm_demod_decimator: decimation, rounding, DC removal,
// FIFO overflow/ordering and asynchronous reset mid-block.
module tb_fm_demod_decimator;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fm_demod_decimator_if #(.FIFO_DEPTH(4)) bus();

   fm_demod_decimator #(.FIFO_DEPTH(4), .DC_SHIFT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int head();
      return int'(bus.out_data);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.enable = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int vals[4];
      int prev, idx, nonmono, neg, zero_run, v;

      bus.enable = 1'b0;
      bus.decim = 3'd0;
      bus.dc_block = 1'b0;
      bus.signal_in = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", head(), 0);
      check("rst_level", bus.level, 0);
      check("rst_overflow", bus.overflow, 0);
      rst = 1'b0;

      // decim=2, constant 1000: result 3 cycles after the 4th sample
      bus.decim = 3'd2; bus.dc_block = 1'b0; bus.signal_in = 16'sd1000;
      bus.out_ready = 1'b1; bus.enable = 1'b1;
      repeat (4) tick();
      tick();
      check("dec4_t2_valid", bus.out_valid, 0);
      tick();
      check("dec4_t3_valid", bus.out_valid, 1);
      check("dec4_t3_data", head(), 1000);
      tick();
      check("dec4_t4_valid", bus.out_valid, 0);
      repeat (3) tick();
      check("dec4_blk2_valid", bus.out_valid, 1);
      check("dec4_blk2_data", head(), 1000);
      bus.enable = 1'b0;
      repeat (6) tick();
      check("dec4_overflow", bus.overflow, 0);

      // decim=1: floor rounding and no wrap at full scale
      do_reset();
      bus.decim = 3'd1; bus.dc_block = 1'b0; bus.out_ready = 1'b1;
      bus.enable = 1'b1; bus.signal_in = -16'sd3;
      tick();
      bus.signal_in = -16'sd4;
      tick();
      bus.signal_in = 16'sd32767;
      tick();
      check("dec2_t2_valid", bus.out_valid, 0);
      tick();
      check("dec2_floor_data", head(), -4);
      bus.enable = 1'b0;
      tick();
      check("dec2_gap_valid", bus.out_valid, 0);
      tick();
      check("dec2_max_valid", bus.out_valid, 1);
      check("dec2_max_data", head(), 32767);

      // DC removal on a constant 256 input decays to zero
      do_reset();
      bus.decim = 3'd0; bus.dc_block = 1'b1; bus.signal_in = 16'sd256;
      bus.out_ready = 1'b1; bus.enable = 1'b1;
      prev = 32767; idx = 0; nonmono = 0; neg = 0; zero_run = 0;
      for (int cyc = 0; cyc < 6000 && zero_run < 50; cyc++) begin
         tick();
         if (bus.out_valid) begin
            v = head();
            if (idx < 4) vals[idx] = v;
            if (v > prev) nonmono++;
            if (v < 0) neg++;
            if (v == 0) zero_run++;
            prev = v;
            idx++;
         end
      end
      bus.enable = 1'b0;
      check("dc_out0", vals[0], 256);
      check("dc_out1", vals[1], 255);
      check("dc_out2", vals[2], 255);
      check("dc_out3", vals[3], 254);
      check("dc_nonincreasing", nonmono, 0);
      check("dc_nonnegative", neg, 0);
      check("dc_settles_zero", zero_run, 50);

      // overflow: six pushes into a 4-deep FIFO with the sink stalled
      do_reset();
      bus.decim = 3'd0; bus.dc_block = 1'b0; bus.out_ready = 1'b0;
      bus.enable = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         bus.signal_in = 16'(k);
         tick();
      end
      bus.enable = 1'b0;
      repeat (3) tick();
      check("ovf_level", bus.level, 4);
      check("ovf_flag", bus.overflow, 1);
      check("ovf_head1", head(), 1);
      bus.out_ready = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         tick();
         check("ovf_drain", head(), k);
      end
      tick();
      check("ovf_empty_valid", bus.out_valid, 0);
      check("ovf_sticky", bus.overflow, 1);

      // full FIFO: push and pop in the same cycle
      do_reset();
      bus.decim = 3'd0; bus.dc_block = 1'b0; bus.out_ready = 1'b0;
      bus.enable = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         bus.signal_in = 16'(k * 10);
         tick();
      end
      bus.signal_in = 16'sd50;
      tick();
      bus.enable = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      check("pp_full_level", bus.level, 4);
      check("pp_pop_head", head(), 10);
      tick();
      bus.out_ready = 1'b0;
      check("pp_level", bus.level, 4);
      check("pp_no_overflow", bus.overflow, 0);
      check("pp_head20", head(), 20);
      bus.out_ready = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         tick();
         check("pp_drain", head(), k * 10);
      end
      tick();
      check("pp_empty", bus.out_valid, 0);

      // decim change mid-block, then reset with entries queued and a block open
      do_reset();
      bus.decim = 3'd0; bus.dc_block = 1'b0; bus.out_ready = 1'b0;
      bus.enable = 1'b1; bus.signal_in = 16'sd100;
      tick();
      bus.signal_in = 16'sd200;
      tick();
      bus.enable = 1'b0;
      repeat (3) tick();
      check("chg_pre_level", bus.level, 2);
      bus.decim = 3'd2; bus.enable = 1'b1; bus.signal_in = 16'sd4;
      tick();
      bus.decim = 3'd0; bus.signal_in = 16'sd8;
      tick();
      bus.signal_in = 16'sd12;
      tick();
      bus.signal_in = 16'sd16;
      tick();
      bus.enable = 1'b0;
      tick();
      check("chg_t2_level", bus.level, 2);
      tick();
      check("chg_t3_level", bus.level, 3);
      check("chg_overflow", bus.overflow, 0);
      bus.out_ready = 1'b1;
      check("chg_head100", head(), 100);
      tick();
      check("chg_head200", head(), 200);
      tick();
      bus.out_ready = 1'b0;
      check("chg_mean_n4", head(), 10);
      bus.enable = 1'b1; bus.signal_in = 16'sd55;
      tick();
      bus.enable = 1'b0;
      repeat (3) tick();
      check("chg_two_queued", bus.level, 2);
      bus.decim = 3'd2; bus.enable = 1'b1; bus.signal_in = 16'sd1000;
      tick();
      tick();
      bus.enable = 1'b0;
      rst = 1'b1;
      #1;
      check("arst_valid", bus.out_valid, 0);
      check("arst_data", head(), 0);
      check("arst_level", bus.level, 0);
      check("arst_overflow", bus.overflow, 0);
      tick();
      rst = 1'b0;
      bus.decim = 3'd0; bus.enable = 1'b1; bus.signal_in = 16'sd7;
      tick();
      bus.enable = 1'b0;
      tick();
      check("post_rst_t2_valid", bus.out_valid, 0);
      tick();
      check("post_rst_t3_valid", bus.out_valid, 1);
      check("post_rst_t3_data", head(), 7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/fm_demod_decimator.md
# fm_demod_decimator

Downstream stage of the FM demodulator. Takes the signed 16-bit demodulated stream at full clock rate, block-averages and decimates it by a runtime power of two, optionally removes DC with a first-order leaky estimator, and buffers results in a small first-word-fall-through FIFO. The FIFO drains over a valid/ready handshake toward the sample sink (capture RAM / host interface).

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- DC_SHIFT, 8, DC estimator time constant: estimate moves by error/2^DC_SHIFT per output
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  sample strobe; input accepted only on cycles with enable=1
- decim  in  3  log2 decimation factor, N = 2^decim (1..128)
- dc_block  in  1  1 = subtract DC estimate, 0 = bypass and hold estimate at 0
- signal_in  in  16  signed demodulated sample
- out_data  out  16  signed FIFO head; 0 when out_valid=0
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts head this cycle
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; set when a result is dropped, cleared only by rst

## Operation
- Accumulator: 23-bit signed acc, 7-bit count. decim_r latched on the enabled cycle where count==0 (block start); decim changes mid-block affect the next block only.
- Enabled cycle, count < 2^decim_r−1: acc += sext(signal_in), count++.
- Enabled cycle, count == 2^decim_r−1: mean = (acc + sext(signal_in)) >>> decim_r (arithmetic, floor), low 16 bits registered into stage-1 with valid; acc, count cleared.
- enable=0: acc, count hold; in-flight stage-1/stage-2 results still complete.
- DC stage (stage-2): dc_est is signed 16+DC_SHIFT bits fixed point; est = dc_est >>> DC_SHIFT. y17 = mean − est (17-bit); y = saturate(y17) to [−32768, 32767]; dc_est += sext(y17). When dc_block=0: y = mean, dc_est cleared to 0.
- FIFO: push y on stage-2 valid. Pop when out_valid && out_ready. Push while full and no pop: result dropped, overflow←1. Push and pop same cycle while full: both succeed, no overflow. Pop while empty: ignored. Order strictly preserved.
- Reset (async, any time including mid-block or with FIFO full): acc, count, decim_r, stage valids, dc_est, FIFO pointers all 0; out_valid=0, out_data=0, level=0, overflow=0. First post-reset block starts at the first enabled cycle after rst deasserts.

## Timing
- Last sample of a block presented with enable in cycle t: stage-1 valid in t+1, FIFO write at end of t+2, out_valid=1 and out_data valid in t+3 (FIFO previously empty).
- Throughput: one result per 2^decim enabled cycles; decim=0 gives one result per enabled cycle, sustained with out_ready=1.
- level updates the cycle after the push/pop edge; out_valid = (level != 0).
- out_data/out_valid change only on clock edges or rst; head stable while out_valid && !out_ready.

## Test plan
- decim=2, dc_block=0, enable=1, signal_in=1000 constant, out_ready=1 → out_data=1000 every 4 cycles; first out_valid 3 cycles after 4th sample; overflow stays 0.
- decim=1, dc_block=0, samples −3, −4 → single output −4 (floor of −3.5); samples 32767, 32767 → 32767 (no wrap).
- DC_SHIFT=8, decim=0, dc_block=1, signal_in=256 constant → outputs 256, 255, … non-increasing, never negative, reach 0 and stay 0.
- FIFO_DEPTH=4, decim=0, out_ready=0, inputs 1..6 on consecutive enabled cycles → level=4, overflow=1; raise out_ready → out_data 1,2,3,4 in order then out_valid=0; overflow remains 1.
- Full FIFO with out_ready=1 and a push in the same cycle → level stays 4, overflow stays 0, popped and pushed values correct.
- decim 2→0 changed at count=1, then rst asserted mid-block with FIFO holding 2 entries → block finishes as N=4; on rst all outputs 0 immediately; after release, decim=0 input 7 → out_data=7 at t+3.
